uart_framer: RTL and testbench

UART_FRAMER -- requirements
Module: uart_framer

---
 rtl/uart_framer_pkg.sv | 37 +++
 rtl/uart_framer_if.sv | 23 ++
 rtl/uart_framer_tx.sv | 89 ++++++++
 rtl/uart_framer.sv | 195 +++++++++++++++++++
 tb/tb_uart_framer.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_framer_pkg.sv
// uart_framer_pkg: payload sizing, FSM state types, checksum helper.
// Optional checksum framing is enabled by defining UART_FRAMER_CHECKSUM_EN.
package uart_framer_pkg;

  localparam int PSIZE  = 84;
  localparam int NBYTES = (PSIZE + 7) / 8;
  localparam int PW     = 8 * NBYTES;

`ifdef UART_FRAMER_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
  typedef enum logic [1:0] {
    RX_HDR, RX_ADDR, RX_DATA, RX_CSUM
  } rx_state_e;
`else
  localparam int CSUM_BYTES = 0;
  typedef enum logic [1:0] {
    RX_HDR, RX_ADDR, RX_DATA
  } rx_state_e;
`endif

  localparam int TXB = NBYTES + CSUM_BYTES;

  typedef enum logic {
    TX_IDLE, TX_SEND
  } tx_state_e;

  function automatic logic [7:0] xor_bytes(
    input logic [PW-1:0] v
  );
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < NBYTES; i++)
      r = r ^ v[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/uart_framer_if.sv
// uart_framer_if: response-in / byte-out handshake bundle.
// Response width follows the shared package; no build options here.
interface uart_framer_if;
  import uart_framer_pkg::*;

  logic             rsp_valid;
  logic [PSIZE-1:0] rsp_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       tx_data;
  logic             rsp_overflow;

  modport master (
    output rsp_valid, rsp_data, tx_ready,
    input  tx_valid, tx_data, rsp_overflow
  );

  modport slave (
    input  rsp_valid, rsp_data, tx_ready,
    output tx_valid, tx_data, rsp_overflow
  );

endinterface

// File: rtl/uart_framer_tx.sv
// uart_framer_tx: one-entry response buffer serialised MSB-first.
// Appends an XOR byte when UART_FRAMER_CHECKSUM_EN is defined.
module uart_framer_tx
  import uart_framer_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  uart_framer_if.slave bus
);

  localparam int TW = 8 * TXB;
  localparam int CW = $clog2(TXB + 1);

  tx_state_e      st_q, st_d;
  logic [TW-1:0]  buf_q, buf_d;
  logic [CW-1:0]  left_q, left_d;
  logic [7:0]     data_q, data_d;
  logic           vld_q, vld_d;
  logic           ovf_q, ovf_d;
  logic [TW-1:0]  load;

  // Frame image of the incoming response, first byte on top.
  always_comb begin
`ifdef UART_FRAMER_CHECKSUM_EN
    load = {PW'(bus.rsp_data), xor_bytes(PW'(bus.rsp_data))};
`else
    load = PW'(bus.rsp_data);
`endif
  end

  // Capture in idle, then one byte per handshake until empty.
  always_comb begin
    st_d   = st_q;
    buf_d  = buf_q;
    left_d = left_q;
    data_d = data_q;
    vld_d  = vld_q;
    ovf_d  = ovf_q;
    unique case (st_q)
      TX_IDLE: begin
        if (bus.rsp_valid) begin
          data_d = load[TW-1 -: 8];
          buf_d  = load << 8;
          left_d = CW'(TXB - 1);
          vld_d  = 1'b1;
          st_d   = TX_SEND;
        end
      end
      TX_SEND: begin
        if (bus.rsp_valid)
          ovf_d = 1'b1;
        if (bus.tx_ready) begin
          if (left_q == '0) begin
            vld_d = 1'b0;
            st_d  = TX_IDLE;
          end else begin
            data_d = buf_q[TW-1 -: 8];
            buf_d  = buf_q << 8;
            left_d = left_q - CW'(1);
          end
        end
      end
    endcase
  end

  // Transmit state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= TX_IDLE;
      buf_q  <= '0;
      left_q <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      buf_q  <= buf_d;
      left_q <= left_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.tx_valid     = vld_q;
  assign bus.tx_data      = data_q;
  assign bus.rsp_overflow = ovf_q;

endmodule

// File: rtl/uart_framer.sv
// uart_framer: UART byte stream <-> command/response framer.
// Checksum framing is enabled by defining UART_FRAMER_CHECKSUM_EN.
module uart_framer
  import uart_framer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             cmd_valid,
  output logic             cmd_wen,
  output logic [13:0]      cmd_addr,
  output logic [PSIZE-1:0] cmd_data,
  input  logic             rsp_valid,
  input  logic [PSIZE-1:0] rsp_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic [7:0]       err_count,
  output logic             rsp_overflow
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(NBYTES + 1);

  rx_state_e        rx_q, rx_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             fwen_q, fwen_d;
  logic [5:0]       fhi_q, fhi_d;
  logic [7:0]       flo_q, flo_d;
  logic [PW-1:0]    pay_q, pay_d;
  logic [PW-1:0]    pay_nx;
  logic             cv_q, cv_d;
  logic             cw_q, cw_d;
  logic [13:0]      ca_q, ca_d;
  logic [PSIZE-1:0] cd_q, cd_d;
  logic [7:0]       err_q, err_d;
`ifdef UART_FRAMER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  // Frame parser, idle timeout and command emission.
  always_comb begin
    rx_d   = rx_q;
    idle_d = idle_q;
    bcnt_d = bcnt_q;
    fwen_d = fwen_q;
    fhi_d  = fhi_q;
    flo_d  = flo_q;
    pay_d  = pay_q;
    cv_d   = 1'b0;
    cw_d   = cw_q;
    ca_d   = ca_q;
    cd_d   = cd_q;
    err_d  = err_q;
    pay_nx = PW'({pay_q, rx_data});
`ifdef UART_FRAMER_CHECKSUM_EN
    csum_d = csum_q;
`endif
    if (rx_valid) begin
      idle_d = '0;
`ifdef UART_FRAMER_CHECKSUM_EN
      csum_d = csum_q ^ rx_data;
`endif
      unique case (rx_q)
        RX_HDR: begin
          fwen_d = rx_data[7];
          fhi_d  = rx_data[5:0];
          pay_d  = '0;
          bcnt_d = '0;
          rx_d   = RX_ADDR;
`ifdef UART_FRAMER_CHECKSUM_EN
          csum_d = rx_data;
`endif
        end
        RX_ADDR: begin
          flo_d = rx_data;
          if (fwen_q) begin
            rx_d = RX_DATA;
          end else begin
`ifdef UART_FRAMER_CHECKSUM_EN
            rx_d = RX_CSUM;
`else
            rx_d = RX_HDR;
            cv_d = 1'b1;
            cw_d = 1'b0;
            ca_d = {fhi_q, rx_data};
            cd_d = '0;
`endif
          end
        end
        RX_DATA: begin
          pay_d = pay_nx;
          if (bcnt_q == BW'(NBYTES - 1)) begin
`ifdef UART_FRAMER_CHECKSUM_EN
            rx_d = RX_CSUM;
`else
            rx_d = RX_HDR;
            cv_d = 1'b1;
            cw_d = 1'b1;
            ca_d = {fhi_q, flo_q};
            cd_d = pay_nx[PSIZE-1:0];
`endif
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
`ifdef UART_FRAMER_CHECKSUM_EN
        RX_CSUM: begin
          rx_d = RX_HDR;
          if (rx_data == csum_q) begin
            cv_d = 1'b1;
            cw_d = fwen_q;
            ca_d = {fhi_q, flo_q};
            cd_d = fwen_q ? pay_q[PSIZE-1:0] : '0;
          end else begin
            err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          end
        end
`endif
        default: rx_d = RX_HDR;
      endcase
    end else if (rx_q != RX_HDR) begin
      if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
        rx_d   = RX_HDR;
        idle_d = '0;
        err_d  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
  end

  // Receive state, frame and command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q   <= RX_HDR;
      idle_q <= '0;
      bcnt_q <= '0;
      fwen_q <= 1'b0;
      fhi_q  <= '0;
      flo_q  <= '0;
      pay_q  <= '0;
      cv_q   <= 1'b0;
      cw_q   <= 1'b0;
      ca_q   <= '0;
      cd_q   <= '0;
      err_q  <= '0;
`ifdef UART_FRAMER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      rx_q   <= rx_d;
      idle_q <= idle_d;
      bcnt_q <= bcnt_d;
      fwen_q <= fwen_d;
      fhi_q  <= fhi_d;
      flo_q  <= flo_d;
      pay_q  <= pay_d;
      cv_q   <= cv_d;
      cw_q   <= cw_d;
      ca_q   <= ca_d;
      cd_q   <= cd_d;
      err_q  <= err_d;
`ifdef UART_FRAMER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end

  assign cmd_valid = cv_q;
  assign cmd_wen   = cw_q;
  assign cmd_addr  = ca_q;
  assign cmd_data  = cd_q;
  assign err_count = err_q;

  uart_framer_if tx_bus ();

  assign tx_bus.rsp_valid = rsp_valid;
  assign tx_bus.rsp_data  = rsp_data;
  assign tx_bus.tx_ready  = tx_ready;
  assign tx_valid         = tx_bus.tx_valid;
  assign tx_data          = tx_bus.tx_data;
  assign rsp_overflow     = tx_bus.rsp_overflow;

  uart_framer_tx u_tx (
    .clk (clk),
    .rst (rst),
    .bus (tx_bus)
  );

endmodule

// File: tb/tb_uart_framer.sv
// tb_uart_framer: random frames and responses vs a byte-level model.
// Build with or without UART_FRAMER_CHECKSUM_EN.
module tb_uart_framer;
  import uart_framer_pkg::*;

  localparam int TO = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             cmd_valid;
  logic             cmd_wen;
  logic [13:0]      cmd_addr;
  logic [PSIZE-1:0] cmd_data;
  logic [7:0]       err_count;

  uart_framer_if u_if ();

  always #5 clk = ~clk;

  uart_framer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .cmd_valid    (cmd_valid),
    .cmd_wen      (cmd_wen),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .rsp_valid    (u_if.rsp_valid),
    .rsp_data     (u_if.rsp_data),
    .tx_valid     (u_if.tx_valid),
    .tx_ready     (u_if.tx_ready),
    .tx_data      (u_if.tx_data),
    .err_count    (err_count),
    .rsp_overflow (u_if.rsp_overflow)
  );

  typedef struct packed {
    logic             wen;
    logic [13:0]      addr;
    logic [PSIZE-1:0] data;
  } cmd_t;

  int         total = 0;
  int         bad = 0;
  cmd_t       cmd_q[$];
  logic [7:0] tx_q[$];
  int         err_exp = 0;
  logic       ovf_exp = 1'b0;
  int         rdy_mode = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ready pattern: 0 always, 1 toggling, 2 random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: u_if.tx_ready = 1'b1;
      1: u_if.tx_ready = ~u_if.tx_ready;
      default: u_if.tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pop the scoreboard on each command and tx handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (cmd_valid) begin
        if (cmd_q.size() == 0) begin
          chk("cmd_spurious", cmd_valid, 0);
        end else begin
          cmd_t e;
          e = cmd_q.pop_front();
          chk("cmd_wen", cmd_wen, e.wen);
          chk("cmd_addr", cmd_addr, e.addr);
          chk("cmd_data", cmd_data, e.data);
        end
      end
      if (prev_stall)
        chk("tx_hold", {u_if.tx_valid, u_if.tx_data}, {1'b1, prev_data});
      if (u_if.tx_valid && u_if.tx_ready) begin
        if (tx_q.size() == 0)
          chk("tx_spurious", u_if.tx_valid, 0);
        else
          chk("tx_byte", u_if.tx_data, tx_q.pop_front());
      end
      prev_stall = u_if.tx_valid && !u_if.tx_ready;
      prev_data  = u_if.tx_data;
    end
  end

  task automatic send_byte(logic [7:0] b, int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
    if (gap > 0) tick(gap);
  endtask

  task automatic send_frame(logic wen, logic b6, logic [13:0] addr,
                            logic [PW-1:0] pay, bit bad_cs,
                            int maxgap, int fixgap);
    logic [7:0] bytes[$];
    logic [7:0] cs;
    cmd_t       e;
    int         g;
    bytes.push_back({wen, b6, addr[13:8]});
    bytes.push_back(addr[7:0]);
    if (wen)
      for (int i = 0; i < NBYTES; i++)
        bytes.push_back(pay[8*(NBYTES-1-i) +: 8]);
    cs = '0;
    foreach (bytes[i]) cs = cs ^ bytes[i];
    if (CSUM_BYTES != 0)
      bytes.push_back(bad_cs ? (cs ^ 8'hA5) : cs);
    if (bad_cs && CSUM_BYTES != 0) begin
      err_exp++;
    end else begin
      e.wen  = wen;
      e.addr = addr;
      e.data = wen ? pay[PSIZE-1:0] : '0;
      cmd_q.push_back(e);
    end
    foreach (bytes[i]) begin
      g = (fixgap >= 0) ? fixgap : $urandom_range(0, maxgap);
      send_byte(bytes[i], g);
    end
  endtask

  task automatic send_rsp(logic [PSIZE-1:0] d, bit drop);
    logic [PW-1:0] v;
    logic [7:0]    cs;
    v  = PW'(d);
    cs = '0;
    if (drop) begin
      ovf_exp = 1'b1;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        tx_q.push_back(v[8*(NBYTES-1-i) +: 8]);
        cs = cs ^ v[8*(NBYTES-1-i) +: 8];
      end
      if (CSUM_BYTES != 0) tx_q.push_back(cs);
    end
    u_if.rsp_valid = 1'b1;
    u_if.rsp_data  = d;
    tick(1);
    u_if.rsp_valid = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while (tx_q.size() != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    if (n >= 2000) chk("tx_drain_timeout", tx_q.size(), 0);
    tick(2);
  endtask

  task automatic wait_cmd();
    int n = 0;
    while (cmd_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) chk("cmd_timeout", cmd_q.size(), 0);
    tick(1);
  endtask

  function automatic logic [PW-1:0] rnd_pay();
    return PW'({$urandom, $urandom, $urandom});
  endfunction

  task automatic rnd_frame();
    bit bad_cs;
    bad_cs = ($urandom_range(0, 3) == 0);
    send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               14'($urandom), rnd_pay(), bad_cs, 5, -1);
  endtask

  task automatic check_zero_outputs(string tag);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_cmd_wen"}, cmd_wen, 0);
    chk({tag, "_cmd_addr"}, cmd_addr, 0);
    chk({tag, "_cmd_data"}, cmd_data, 0);
    chk({tag, "_tx_valid"}, u_if.tx_valid, 0);
    chk({tag, "_tx_data"}, u_if.tx_data, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_rsp_overflow"}, u_if.rsp_overflow, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] pay;
    rst            = 1'b1;
    rx_valid       = 1'b0;
    rx_data        = '0;
    u_if.rsp_valid = 1'b0;
    u_if.rsp_data  = '0;
    u_if.tx_ready  = 1'b1;
    tick(3);
    check_zero_outputs("reset");
    rst = 1'b0;
    tick(2);

    // Directed write frame 0x81 0x23 0x00..0x0A.
    for (int i = 0; i < NBYTES; i++)
      pay[8*(NBYTES-1-i) +: 8] = 8'(i);
    send_frame(1'b1, 1'b0, 14'h0123, pay, 0, 0, 0);
    wait_cmd();

    // Directed read frame 0x20 0x05.
    send_frame(1'b0, 1'b0, 14'h2005, rnd_pay(), 0, 0, 0);
    wait_cmd();

    // Header bit 6 must be ignored.
    send_frame(1'b0, 1'b1, 14'h3FAA, '0, 0, 2, -1);
    wait_cmd();

    // Timeout after a lone header, then a clean frame.
    send_byte(8'h81, 0);
    tick(TO);
    err_exp++;
    tick(2);
    chk("err_after_timeout", err_count, 8'(err_exp));
    send_frame(1'b1, 1'b0, 14'h1ABC, rnd_pay(), 0, 3, -1);
    wait_cmd();

    // A byte arriving on the last idle cycle still wins.
    send_frame(1'b1, 1'b0, 14'h0ACE, rnd_pay(), 0, 0, TO - 1);
    wait_cmd();
    chk("err_edge_gap", err_count, 8'(err_exp));

`ifdef UART_FRAMER_CHECKSUM_EN
    send_frame(1'b1, 1'b0, 14'h0555, rnd_pay(), 1, 2, -1);
    tick(3);
    chk("err_bad_csum", err_count, 8'(err_exp));
    send_frame(1'b0, 1'b0, 14'h0777, '0, 1, 2, -1);
    tick(3);
    chk("err_bad_csum_rd", err_count, 8'(err_exp));
`endif

    // Response of 1 under toggling back-pressure.
    rdy_mode = 1;
    send_rsp(PSIZE'(1), 0);
    wait_tx_idle();
    chk("ovf_clear", u_if.rsp_overflow, ovf_exp);

    // Second response while sending is dropped.
    send_rsp(PSIZE'({$urandom, $urandom, $urandom}), 0);
    tick(2);
    send_rsp(PSIZE'({$urandom, $urandom, $urandom}), 1);
    wait_tx_idle();
    chk("ovf_set", u_if.rsp_overflow, ovf_exp);

    // Concurrent random receive and transmit traffic.
    rdy_mode = 2;
    fork
      begin
        for (int i = 0; i < 30; i++) rnd_frame();
      end
      begin
        for (int i = 0; i < 12; i++) begin
          wait_tx_idle();
          tick($urandom_range(0, 3));
          send_rsp(PSIZE'({$urandom, $urandom, $urandom}), 0);
        end
      end
    join
    wait_cmd();
    wait_tx_idle();
    chk("err_random", err_count, 8'(err_exp));
    chk("ovf_random", u_if.rsp_overflow, ovf_exp);

    // Reset in the middle of a frame and a response.
    rdy_mode = 0;
    send_byte(8'h81, 0);
    send_byte(8'h12, 0);
    send_rsp(PSIZE'({$urandom, $urandom, $urandom}), 0);
    tick(2);
    rst = 1'b1;
    cmd_q.delete();
    tx_q.delete();
    err_exp = 0;
    ovf_exp = 1'b0;
    tick(1);
    check_zero_outputs("midrst");
    rst = 1'b0;
    tick(TO + 5);
    chk("post_rst_tx_valid", u_if.tx_valid, 0);
    chk("post_rst_err", err_count, 8'(err_exp));
    send_frame(1'b0, 1'b0, 14'h0042, '0, 0, 1, -1);
    wait_cmd();
    send_rsp(PSIZE'(16'hBEEF), 0);
    wait_tx_idle();

    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("tx_q_empty", tx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
